// File: rtl/atm_bank_pkg.sv
// Shared encodings for the ATM bank responder: op codes, status codes,
// FSM states and the per-card account record.
package atm_bank_pkg;

    localparam int AMT_W  = 32;
    localparam int PIN_W  = 4;
    localparam int FAIL_W = 4;

    typedef enum logic [2:0] {
        OP_VERIFY   = 3'd0,
        OP_BALANCE  = 3'd1,
        OP_DEPOSIT  = 3'd2,
        OP_WITHDRAW = 3'd3,
        OP_END      = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        STAT_OK           = 3'd0,
        STAT_BAD_PIN      = 3'd1,
        STAT_LOCKED       = 3'd2,
        STAT_INSUFFICIENT = 3'd3,
        STAT_NO_SESSION   = 3'd4,
        STAT_BAD_CARD     = 3'd5,
        STAT_OVERFLOW     = 3'd6,
        STAT_BAD_OP       = 3'd7
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIN_W-1:0]  pin;
        logic [AMT_W-1:0]  balance;
        logic [FAIL_W-1:0] fail_cnt;
        logic              locked;
    } acct_t;

endpackage

// File: rtl/atm_bank_responder_if.sv
// Request/response channels between the ATM FSM (master) and the bank responder (slave).
// Handshake: a beat transfers on the rising edge where valid and ready are both 1;
// the sender holds valid and its payload stable until that edge.
interface atm_bank_responder_if #(
    parameter int ID_W = 2
);
    import atm_bank_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [ID_W-1:0]  req_card;
    logic [PIN_W-1:0] req_pin;
    logic [AMT_W-1:0] req_amount;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_status;
    logic [AMT_W-1:0] rsp_balance;
    logic             session_open;

    modport master (
        output req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance, session_open
    );

    modport slave (
        input  req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance, session_open
    );

endinterface

// File: rtl/atm_account_table.sv
// Per-card account storage: one combinational read port, one synchronous write port.
module atm_account_table
    import atm_bank_pkg::*;
#(
    parameter int               NUM_ACCOUNTS = 4,
    parameter int               ID_W         = 2,
    parameter logic [AMT_W-1:0] INIT_BALANCE = 32'h000F4240,
    parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'b1010
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [ID_W-1:0] rd_idx,
    output acct_t           rd_entry,
    input  logic            wr_en,
    input  logic [ID_W-1:0] wr_idx,
    input  acct_t           wr_entry
);

    localparam acct_t INIT_ENTRY = '{
        pin:      DEFAULT_PIN,
        balance:  INIT_BALANCE,
        fail_cnt: '0,
        locked:   1'b0
    };

    acct_t mem [NUM_ACCOUNTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                mem[i] <= INIT_ENTRY;
            end
        end else if (wr_en && (int'(wr_idx) < NUM_ACCOUNTS)) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // Out-of-range ids read as an all-zero record; the top reports them as BAD_CARD.
    assign rd_entry = (int'(rd_idx) < NUM_ACCOUNTS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/atm_bank_responder.sv
// Bank-side responder: one request at a time through IDLE -> EXEC -> RESP,
// with session ownership, PIN lockout and an idle-session timeout.
module atm_bank_responder
    import atm_bank_pkg::*;
#(
    parameter int               NUM_ACCOUNTS    = 4,
    parameter int               ID_W            = 2,
    parameter logic [AMT_W-1:0] INIT_BALANCE    = 32'h000F4240,
    parameter logic [PIN_W-1:0] DEFAULT_PIN     = 4'b1010,
    parameter int               MAX_TRIES       = 3,
    parameter int               SESSION_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    atm_bank_responder_if.slave  bus,
    output state_t               dbg_state
);

    localparam int              TMR_W    = $clog2(SESSION_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SESSION_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             accept, exec;
    logic [2:0]       op_q;
    logic [ID_W-1:0]  card_q;
    logic [PIN_W-1:0] pin_q;
    logic [AMT_W-1:0] amt_q;

    status_t          status_q, status_d;
    logic [AMT_W-1:0] bal_q, bal_d;

    logic             sess_q;
    logic [ID_W-1:0]  owner_q;
    logic             sess_set, sess_clr;
    logic [TMR_W-1:0] timer_q;

    acct_t            rd_entry, wr_entry;
    logic             wr_req;
    logic [AMT_W:0]   sum;
    logic [FAIL_W-1:0] fail_next;
    logic             card_ok, owner_match;

    assign accept    = bus.req_valid && (state_q == ST_IDLE);
    assign exec      = (state_q == ST_EXEC);
    assign dbg_state = state_q;

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_status   = status_q;
    assign bus.rsp_balance  = bal_q;
    assign bus.session_open = sess_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            card_q <= '0;
            pin_q  <= '0;
            amt_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.req_op;
            card_q <= bus.req_card;
            pin_q  <= bus.req_pin;
            amt_q  <= bus.req_amount;
        end
    end

    atm_account_table #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .ID_W         (ID_W),
        .INIT_BALANCE (INIT_BALANCE),
        .DEFAULT_PIN  (DEFAULT_PIN)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (card_q),
        .rd_entry (rd_entry),
        .wr_en    (wr_req && exec),
        .wr_idx   (card_q),
        .wr_entry (wr_entry)
    );

    // Status decode in priority order; the first matching check decides the response.
    always_comb begin
        status_d    = STAT_OK;
        bal_d       = rd_entry.balance;
        wr_req      = 1'b0;
        wr_entry    = rd_entry;
        sess_set    = 1'b0;
        sess_clr    = 1'b0;
        sum         = {1'b0, rd_entry.balance} + {1'b0, amt_q};
        fail_next   = rd_entry.fail_cnt + FAIL_W'(1);
        card_ok     = (int'(card_q) < NUM_ACCOUNTS);
        owner_match = sess_q && (owner_q == card_q);

        if (op_q > 3'd4) begin
            status_d = STAT_BAD_OP;
        end else if (!card_ok) begin
            status_d = STAT_BAD_CARD;
            bal_d    = '0;
        end else if (rd_entry.locked) begin
            status_d = STAT_LOCKED;
            bal_d    = '0;
        end else if ((op_q != OP_VERIFY) && !owner_match) begin
            status_d = STAT_NO_SESSION;
            bal_d    = '0;
        end else begin
            case (op_q)
                OP_VERIFY: begin
                    wr_req = 1'b1;
                    if (pin_q == rd_entry.pin) begin
                        wr_entry.fail_cnt = '0;
                        sess_set          = 1'b1;
                    end else begin
                        status_d          = STAT_BAD_PIN;
                        wr_entry.fail_cnt = fail_next;
                        if (int'(fail_next) >= MAX_TRIES) begin
                            wr_entry.locked = 1'b1;
                            sess_clr        = 1'b1;
                        end
                    end
                end
                OP_DEPOSIT: begin
                    if (sum[AMT_W]) begin
                        status_d = STAT_OVERFLOW;
                    end else begin
                        wr_req           = 1'b1;
                        wr_entry.balance = sum[AMT_W-1:0];
                        bal_d            = sum[AMT_W-1:0];
                    end
                end
                OP_WITHDRAW: begin
                    if (amt_q > rd_entry.balance) begin
                        status_d = STAT_INSUFFICIENT;
                    end else begin
                        wr_req           = 1'b1;
                        wr_entry.balance = rd_entry.balance - amt_q;
                        bal_d            = rd_entry.balance - amt_q;
                    end
                end
                OP_END:  sess_clr = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= STAT_OK;
            bal_q    <= '0;
        end else if (exec) begin
            status_q <= status_d;
            bal_q    <= bal_d;
        end
    end

    // An accepted request restarts the idle timer, so it beats a same-edge timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sess_q  <= 1'b0;
            owner_q <= '0;
            timer_q <= '0;
        end else begin
            if (accept) begin
                timer_q <= '0;
            end else if ((state_q == ST_IDLE) && sess_q) begin
                if (timer_q == TMR_LAST) begin
                    timer_q <= '0;
                    sess_q  <= 1'b0;
                end else begin
                    timer_q <= timer_q + TMR_W'(1);
                end
            end
            if (exec && sess_set) begin
                sess_q  <= 1'b1;
                owner_q <= card_q;
            end else if (exec && sess_clr) begin
                sess_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Bench for atm_bank_responder: vector table plus hand-written backpressure,
// mid-transaction reset and session-timeout sequences, checked by an expected-response queue.
module tb_atm_bank_responder;

    localparam logic [2:0] T_VERIFY = 3'd0, T_BAL = 3'd1, T_DEP = 3'd2, T_WD = 3'd3, T_END = 3'd4;
    localparam logic [2:0] E_OK = 3'd0, E_BAD_PIN = 3'd1, E_LOCKED = 3'd2, E_INSUF = 3'd3;
    localparam logic [2:0] E_NOSESS = 3'd4, E_OVF = 3'd6, E_BAD_OP = 3'd7;
    localparam logic [3:0] PIN_OK = 4'b1010;
    localparam logic [31:0] INIT_BAL = 32'd1000000;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  card;
        logic [3:0]  pin;
        logic [31:0] amt;
        logic [2:0]  st;
        logic [31:0] bal;
        logic        sess;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    atm_bank_responder_if #(.ID_W(2)) bus ();
    atm_bank_pkg::state_t dbg_state;

    atm_bank_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [34:0] exp_q[$];
    logic [34:0] sb_e;
    string       cur_name = "reset";
    vec_t        vecs[$];
    bit          ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // scoreboard: compare every response beat against the expected queue
    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                fail_now({cur_name, " unexpected rsp"});
            end else begin
                sb_e = exp_q.pop_front();
                check({cur_name, " rsp_status"}, {29'b0, bus.rsp_status}, {29'b0, sb_e[34:32]});
                check({cur_name, " rsp_balance"}, bus.rsp_balance, sb_e[31:0]);
            end
        end
    end

    // driver: present one request and hold it until accepted
    task automatic drive_req(input logic [2:0] op, input logic [1:0] card, input logic [3:0] pin,
                             input logic [31:0] amt, output bit acc);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_card   = card;
        bus.req_pin    = pin;
        bus.req_amount = amt;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = bus.req_ready;
        if (!acc) fail_now({cur_name, " req_ready"});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] card, input logic [3:0] pin,
                        input logic [31:0] amt, input logic [2:0] es, input logic [31:0] eb);
        bit acc;
        int n;
        exp_q.push_back({es, eb});
        drive_req(op, card, pin, amt, acc);
        if (!acc) begin
            void'(exp_q.pop_back());
            return;
        end
        @(negedge clk);
        check({cur_name, " rsp_valid in EXEC"}, {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check({cur_name, " rsp_valid at T+2"}, {31'b0, bus.rsp_valid}, 32'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now({cur_name, " rsp timeout"});
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        fail_now("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_card   = '0;
        bus.req_pin    = '0;
        bus.req_amount = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("reset rsp_status", {29'b0, bus.rsp_status}, 32'd0);
        check("reset rsp_balance", bus.rsp_balance, 32'd0);
        check("reset session_open", {31'b0, bus.session_open}, 32'd0);
        check("reset state", {30'b0, dbg_state}, 32'd0);

        vecs.push_back('{T_VERIFY, 2'd1, PIN_OK, 32'd0, E_OK, INIT_BAL, 1'b1});
        vecs.push_back('{T_DEP, 2'd1, 4'd0, 32'd500, E_OK, 32'd1000500, 1'b1});
        vecs.push_back('{T_WD, 2'd1, 4'd0, 32'd1000500, E_OK, 32'd0, 1'b1});
        vecs.push_back('{T_WD, 2'd1, 4'd0, 32'd1, E_INSUF, 32'd0, 1'b1});
        vecs.push_back('{T_WD, 2'd1, 4'd0, 32'd0, E_OK, 32'd0, 1'b1});
        vecs.push_back('{T_END, 2'd1, 4'd0, 32'd0, E_OK, 32'd0, 1'b0});
        vecs.push_back('{T_BAL, 2'd1, 4'd0, 32'd0, E_NOSESS, 32'd0, 1'b0});
        vecs.push_back('{T_VERIFY, 2'd2, 4'd0, 32'd0, E_BAD_PIN, INIT_BAL, 1'b0});
        vecs.push_back('{T_VERIFY, 2'd2, 4'd0, 32'd0, E_BAD_PIN, INIT_BAL, 1'b0});
        vecs.push_back('{T_VERIFY, 2'd2, 4'd0, 32'd0, E_BAD_PIN, INIT_BAL, 1'b0});
        vecs.push_back('{T_VERIFY, 2'd2, PIN_OK, 32'd0, E_LOCKED, 32'd0, 1'b0});
        vecs.push_back('{T_VERIFY, 2'd0, PIN_OK, 32'd0, E_OK, INIT_BAL, 1'b1});
        vecs.push_back('{T_DEP, 2'd0, 4'd0, 32'hFFFFFFFF, E_OVF, INIT_BAL, 1'b1});
        vecs.push_back('{T_BAL, 2'd3, 4'd0, 32'd0, E_NOSESS, 32'd0, 1'b1});
        vecs.push_back('{T_BAL, 2'd0, 4'd0, 32'd0, E_OK, INIT_BAL, 1'b1});
        vecs.push_back('{T_DEP, 2'd1, 4'd0, 32'd5, E_NOSESS, 32'd0, 1'b1});
        vecs.push_back('{3'd5, 2'd0, 4'd0, 32'd0, E_BAD_OP, INIT_BAL, 1'b1});
        vecs.push_back('{T_BAL, 2'd2, 4'd0, 32'd0, E_LOCKED, 32'd0, 1'b1});
        vecs.push_back('{T_VERIFY, 2'd3, 4'd3, 32'd0, E_BAD_PIN, INIT_BAL, 1'b1});
        vecs.push_back('{T_VERIFY, 2'd3, PIN_OK, 32'd0, E_OK, INIT_BAL, 1'b1});
        vecs.push_back('{T_BAL, 2'd0, 4'd0, 32'd0, E_NOSESS, 32'd0, 1'b1});
        vecs.push_back('{T_DEP, 2'd3, 4'd0, 32'd1, E_OK, 32'd1000001, 1'b1});
        vecs.push_back('{T_WD, 2'd3, 4'd0, 32'd1, E_OK, INIT_BAL, 1'b1});
        vecs.push_back('{T_VERIFY, 2'd3, 4'd3, 32'd0, E_BAD_PIN, INIT_BAL, 1'b1});
        vecs.push_back('{T_VERIFY, 2'd3, 4'd3, 32'd0, E_BAD_PIN, INIT_BAL, 1'b1});
        vecs.push_back('{T_VERIFY, 2'd3, PIN_OK, 32'd0, E_OK, INIT_BAL, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            cur_name = $sformatf("vec%0d", i);
            send(vecs[i].op, vecs[i].card, vecs[i].pin, vecs[i].amt, vecs[i].st, vecs[i].bal);
            check({cur_name, " session_open"}, {31'b0, bus.session_open}, {31'b0, vecs[i].sess});
        end

        // backpressure: response held while a competing request is offered
        cur_name = "backpressure";
        bus.rsp_ready = 1'b0;
        exp_q.push_back({E_OK, INIT_BAL});
        drive_req(T_BAL, 2'd3, 4'd0, 32'd0, ok);
        @(negedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = T_DEP;
        bus.req_card   = 2'd3;
        bus.req_amount = 32'd100;
        for (int i = 0; i < 5; i++) begin
            check("bp rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("bp req_ready", {31'b0, bus.req_ready}, 32'd0);
            check("bp rsp_status", {29'b0, bus.rsp_status}, {29'b0, E_OK});
            check("bp rsp_balance", bus.rsp_balance, INIT_BAL);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            fail_now("bp rsp timeout");
            exp_q.delete();
        end
        @(negedge clk);
        check("bp back to idle", {30'b0, dbg_state}, 32'd0);
        cur_name = "bp no second request";
        send(T_BAL, 2'd3, 4'd0, 32'd0, E_OK, INIT_BAL);

        // reset asserted while a withdraw is in EXEC
        cur_name = "reset_exec";
        drive_req(T_WD, 2'd3, 4'd0, 32'd500, ok);
        check("rx in exec", {30'b0, dbg_state}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rx state", {30'b0, dbg_state}, 32'd0);
        check("rx rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rx session_open", {31'b0, bus.session_open}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        send(T_BAL, 2'd3, 4'd0, 32'd0, E_NOSESS, 32'd0);
        send(T_VERIFY, 2'd3, PIN_OK, 32'd0, E_OK, INIT_BAL);
        cur_name = "unlock after reset";
        send(T_VERIFY, 2'd2, PIN_OK, 32'd0, E_OK, INIT_BAL);

        // idle session timeout
        cur_name = "timeout";
        repeat (1000) @(negedge clk);
        check("timeout still open", {31'b0, bus.session_open}, 32'd1);
        repeat (30) @(negedge clk);
        check("timeout closed", {31'b0, bus.session_open}, 32'd0);
        send(T_BAL, 2'd2, 4'd0, 32'd0, E_NOSESS, 32'd0);

        repeat (3) @(negedge clk);
        check("queue drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
